if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 123 ++++++++++++
 tb/tb_if_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: fetches 16-bit words from a combinational instruction
// memory into a small in-order buffer and presents the head entry to decode.
// Redirects flush the buffer and restart fetching; HALT stops fetching until a
// redirect or reset; an unaligned fetch parks the unit in ERR with a sticky flag.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err,
    output logic [15:0] ins,
    output logic [15:0] ins_pc,
    output logic [15:0] ins_pc_next,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        fetch_err,
    output logic        halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ERR  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   pc;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [15:0]   buf_ins [DEPTH];
    logic [15:0]   buf_pc  [DEPTH];

    logic push;
    logic fault;
    logic pop;

    // Fetch request: only in RUN with room in the buffer, and never in a cycle
    // that is being overridden by reset, redirect or halt.
    always_comb begin
        mem_en = !rst && (state == RUN) && (count < CW'(DEPTH))
                 && !redirect_valid && !halt_req;
    end

    assign mem_addr  = pc;
    assign mem_wr    = 1'b0;
    assign mem_wdata = 16'h0000;

    assign ins_valid   = (state != HALT) && (count != '0);
    assign ins         = buf_ins[head];
    assign ins_pc      = buf_pc[head];
    assign ins_pc_next = ins_pc + 16'd2;
    assign halted      = (state == HALT);

    // Push and pop qualifiers; pops are suppressed in cycles that flush.
    always_comb begin
        push  = mem_en && !mem_err;
        fault = mem_en && mem_err;
        pop   = ins_valid && ins_ready && !rst && !redirect_valid && !halt_req;
    end

    // Control state, PC, occupancy and pointers with rst > redirect > halt > fetch/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            fetch_err <= 1'b0;
        end else if (redirect_valid) begin
            state     <= RUN;
            pc        <= redirect_pc;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            fetch_err <= 1'b0;
        end else if (halt_req) begin
            state <= HALT;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (fault) begin
                state     <= ERR;
                fetch_err <= 1'b1;
            end
            if (push) begin
                tail <= tail + PW'(1);
                pc   <= pc + 16'd2;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage: write the fetched word and its address at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_ins[tail] <= mem_rdata;
            buf_pc[tail]  <= pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a queue-based behavioural model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_if_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic [15:0] ins_pc_next;
    logic        ins_valid;
    logic        ins_ready;
    logic        fetch_err;
    logic        halted;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] addr;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] mPc;
    bit          mHalt;
    bit          mErrState;
    bit          mErrFlag;
    bit          mLive = 1'b0;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_pc_next    (ins_pc_next),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .fetch_err      (fetch_err),
        .halted         (halted)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Instruction memory contents.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1111;
        if (a == 16'h0002) return 16'h2222;
        return a ^ 16'h5A5A;
    endfunction

    assign mem_rdata = memWord(mem_addr);
    assign mem_err   = mem_en & mem_addr[0];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin : compareModel
        bit eEn;
        bit eValid;
        bit doFetch;
        bit doPop;
        if (mLive) begin
            eEn    = !rst && !mHalt && !mErrState && (mq.size() < DEPTH)
                     && !redirect_valid && !halt_req;
            eValid = !mHalt && (mq.size() != 0);
            checkOutput("model mem_en", {15'd0, mem_en}, {15'd0, eEn});
            if (eEn) checkOutput("model mem_addr", mem_addr, mPc);
            checkOutput("model ins_valid", {15'd0, ins_valid}, {15'd0, eValid});
            if (eValid) begin
                checkOutput("model ins", ins, mq[0].word);
                checkOutput("model ins_pc", ins_pc, mq[0].addr);
                checkOutput("model ins_pc_next", ins_pc_next, mq[0].addr + 16'd2);
            end
            checkOutput("model fetch_err", {15'd0, fetch_err}, {15'd0, mErrFlag});
            checkOutput("model halted", {15'd0, halted}, {15'd0, mHalt});
            checkOutput("model mem_wr", {15'd0, mem_wr}, 16'd0);
            checkOutput("model mem_wdata", mem_wdata, 16'd0);
        end
        if (rst) begin
            mq.delete();
            mPc       = RESET_PC;
            mHalt     = 1'b0;
            mErrState = 1'b0;
            mErrFlag  = 1'b0;
            mLive     = 1'b1;
        end else if (mLive) begin
            if (redirect_valid) begin
                mq.delete();
                mPc       = redirect_pc;
                mHalt     = 1'b0;
                mErrState = 1'b0;
                mErrFlag  = 1'b0;
            end else if (halt_req) begin
                mq.delete();
                mHalt     = 1'b1;
                mErrState = 1'b0;
            end else begin
                doFetch = !mHalt && !mErrState && (mq.size() < DEPTH);
                doPop   = !mHalt && (mq.size() != 0) && ins_ready;
                if (doPop) void'(mq.pop_front());
                if (doFetch) begin
                    if (mPc[0]) begin
                        mErrState = 1'b1;
                        mErrFlag  = 1'b1;
                    end else begin
                        mq.push_back({memWord(mPc), mPc});
                        mPc = mPc + 16'd2;
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return mid-cycle.
    task automatic applyStimulus(input logic r, input logic rv, input logic [15:0] rpc,
                                 input logic h, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        ins_ready      = rdy;
        @(negedge clk);
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        int          fetches;
        logic [15:0] readyPat;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt_req       = 1'b0;
        ins_ready      = 1'b1;

        applyStimulus(1, 0, 16'h0000, 0, 1);
        applyStimulus(1, 0, 16'h0000, 0, 1);
        checkOutput("reset mem_en", {15'd0, mem_en}, 16'd0);
        checkOutput("reset ins_valid", {15'd0, ins_valid}, 16'd0);
        checkOutput("reset fetch_err", {15'd0, fetch_err}, 16'd0);
        checkOutput("reset halted", {15'd0, halted}, 16'd0);

        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("first fetch en", {15'd0, mem_en}, 16'd1);
        checkOutput("first fetch addr", mem_addr, 16'h0000);
        checkOutput("first fetch no valid", {15'd0, ins_valid}, 16'd0);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("first ins valid", {15'd0, ins_valid}, 16'd1);
        checkOutput("first ins", ins, 16'h1111);
        checkOutput("first ins_pc", ins_pc, 16'h0000);
        checkOutput("first ins_pc_next", ins_pc_next, 16'h0002);

        applyStimulus(1, 0, 16'h0000, 0, 0);
        fetches = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, 0);
            if (mem_en) begin
                checkOutput("stall fetch addr", mem_addr, 16'(fetches * 2));
                fetches++;
            end
            if (i > 0) checkOutput("stall ins hold", ins, 16'h1111);
        end
        checkOutput("stall fetch count", 16'(fetches), 16'd2);
        checkOutput("stall mem_en off", {15'd0, mem_en}, 16'd0);

        applyStimulus(0, 1, 16'h0040, 0, 0);
        checkOutput("redirect cycle mem_en", {15'd0, mem_en}, 16'd0);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("post redirect valid", {15'd0, ins_valid}, 16'd0);
        checkOutput("post redirect en", {15'd0, mem_en}, 16'd1);
        checkOutput("post redirect addr", mem_addr, 16'h0040);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("redirect ins", ins, 16'h5A1A);
        checkOutput("redirect ins_pc", ins_pc, 16'h0040);

        applyStimulus(0, 1, 16'h0041, 0, 1);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("odd fetch en", {15'd0, mem_en}, 16'd1);
        checkOutput("odd fetch addr", mem_addr, 16'h0041);
        checkOutput("odd mem_err", {15'd0, mem_err}, 16'd1);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("err flag set", {15'd0, fetch_err}, 16'd1);
        checkOutput("err no fetch", {15'd0, mem_en}, 16'd0);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("err still no fetch", {15'd0, mem_en}, 16'd0);
        applyStimulus(0, 1, 16'h0050, 0, 1);
        checkOutput("err flag until edge", {15'd0, fetch_err}, 16'd1);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("err flag cleared", {15'd0, fetch_err}, 16'd0);
        checkOutput("recover fetch addr", mem_addr, 16'h0050);
        checkOutput("recover fetch en", {15'd0, mem_en}, 16'd1);

        applyStimulus(0, 1, 16'hFFFE, 0, 1);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("wrap fetch addr", mem_addr, 16'hFFFE);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("wrap ins_pc", ins_pc, 16'hFFFE);
        checkOutput("wrap ins_pc_next", ins_pc_next, 16'h0000);
        checkOutput("wrap ins", ins, 16'hA5A4);
        checkOutput("wrap next addr", mem_addr, 16'h0000);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("wrap second ins", ins, 16'h1111);

        applyStimulus(0, 1, 16'h0100, 1, 1);
        checkOutput("both req mem_en", {15'd0, mem_en}, 16'd0);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("redirect wins halted", {15'd0, halted}, 16'd0);
        checkOutput("redirect wins addr", mem_addr, 16'h0100);
        applyStimulus(0, 0, 16'h0000, 1, 1);
        checkOutput("halt req mem_en", {15'd0, mem_en}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, 1);
            checkOutput("halt halted", {15'd0, halted}, 16'd1);
            checkOutput("halt mem_en", {15'd0, mem_en}, 16'd0);
            checkOutput("halt ins_valid", {15'd0, ins_valid}, 16'd0);
        end
        applyStimulus(1, 0, 16'h0000, 0, 1);
        applyStimulus(0, 0, 16'h0000, 0, 1);
        checkOutput("unhalt halted", {15'd0, halted}, 16'd0);
        checkOutput("unhalt fetch addr", mem_addr, RESET_PC);
        checkOutput("unhalt fetch en", {15'd0, mem_en}, 16'd1);

        readyPat = 16'b1011_0010_0111_0001;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, readyPat[i]);
        end
        applyStimulus(0, 0, 16'h0000, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
